// File: rtl/mem_sys_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sys_pkg
//  Description : Shared defaults and the ROB entry record for the D$ <-> ROB
//                retire path.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_sys_pkg;

    localparam int c_DEPTH        = 16;
    localparam int c_OOO_TAG_SIZE = 10;
    localparam int c_OOO_ROB_SIZE = 10;
    localparam int c_XLEN         = 32;

    // One in-order ROB slot. The tag and data widths follow the package defaults.
    typedef struct packed {
        logic                      vld;
        logic                      done;
        logic                      is_st;
        logic                      flush;
        logic [c_OOO_TAG_SIZE-1:0] tag;
        logic [c_XLEN-1:0]         data;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_entry_table.sv
`default_nettype none
// ============================================================================
//  Module      : rob_entry_table
//  Description : ROB entry storage with allocate, complete and clear write
//                ports plus an asynchronous head read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_entry_table
    import mem_sys_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush_all,
    input  logic                      i_alloc_en,
    input  logic [PTR_W-1:0]          i_alloc_idx,
    input  logic [c_OOO_TAG_SIZE-1:0] i_alloc_tag,
    input  logic                      i_alloc_is_st,
    input  logic                      i_cmp_en,
    input  logic [PTR_W-1:0]          i_cmp_idx,
    input  logic [c_OOO_TAG_SIZE-1:0] i_cmp_tag,
    input  logic [c_XLEN-1:0]         i_cmp_data,
    input  logic                      i_cmp_is_flush,
    input  logic                      i_clr_en,
    input  logic [PTR_W-1:0]          i_clr_idx,
    input  logic [PTR_W-1:0]          i_head_idx,
    output rob_entry_t                o_head
);

    rob_entry_t r_entries [DEPTH];

    // Entry updates. A completion only lands on a live entry whose tag still
    // matches; stale responses fall through. Clear is written last so a
    // retiring head is never revived by a same-cycle completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (i_flush_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (i_cmp_en && r_entries[i_cmp_idx].vld &&
                (r_entries[i_cmp_idx].tag == i_cmp_tag)) begin
                r_entries[i_cmp_idx].done  <= 1'b1;
                r_entries[i_cmp_idx].flush <= i_cmp_is_flush;
                r_entries[i_cmp_idx].data  <= r_entries[i_cmp_idx].is_st ? '0 : i_cmp_data;
            end
            if (i_alloc_en) begin
                r_entries[i_alloc_idx] <= '{vld:   1'b1,
                                            done:  1'b0,
                                            is_st: i_alloc_is_st,
                                            flush: 1'b0,
                                            tag:   i_alloc_tag,
                                            data:  '0};
            end
            if (i_clr_en) begin
                r_entries[i_clr_idx] <= '0;
            end
        end
    end

    assign o_head = r_entries[i_head_idx];

endmodule
`default_nettype wire

// File: rtl/dc_rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dc_rob_retire_ctrl
//  Description : ROB-side retire controller. Allocates in-order entries for
//                memory ops, absorbs D$ completions and retires strictly in
//                order, returning store-retire tags and resteer pulses to D$.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_rob_retire_ctrl
    import mem_sys_pkg::*;
#(
    parameter int DEPTH        = c_DEPTH,
    parameter int OOO_TAG_SIZE = c_OOO_TAG_SIZE,
    parameter int OOO_ROB_SIZE = c_OOO_ROB_SIZE,
    parameter int XLEN         = c_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [OOO_TAG_SIZE-1:0] alloc_tag,
    input  logic                    alloc_is_st,
    output logic                    alloc_ready,
    output logic [OOO_ROB_SIZE-1:0] alloc_line,
    input  logic                    cmp_valid,
    input  logic [OOO_ROB_SIZE-1:0] cmp_line,
    input  logic [OOO_TAG_SIZE-1:0] cmp_tag,
    input  logic [XLEN-1:0]         cmp_data,
    input  logic                    cmp_is_flush,
    output logic [OOO_TAG_SIZE-1:0] rob_ret_tag_in,
    output logic                    rob_valid,
    output logic                    rob_resteer,
    output logic                    ret_valid,
    output logic [OOO_TAG_SIZE-1:0] ret_tag,
    output logic [XLEN-1:0]         ret_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    rob_entry_t w_head;
    logic       w_retire;
    logic       w_flush;
    logic       w_alloc;
    logic       w_line_ok;
    logic       w_cmp_en;

    // Readiness uses the pre-edge count, so a retire in the same cycle never
    // opens a slot for a full ROB.
    assign alloc_ready = (r_count < c_CNT_W'(DEPTH));
    assign alloc_line  = OOO_ROB_SIZE'(r_tail);
    assign count       = r_count;

    assign w_retire  = w_head.vld && w_head.done;
    assign w_flush   = w_retire && w_head.flush;
    // A flushing retire wipes the table, so same-cycle writes are dropped.
    assign w_alloc   = alloc_valid && alloc_ready && !w_flush;
    assign w_line_ok = (cmp_line < OOO_ROB_SIZE'(DEPTH));
    assign w_cmp_en  = cmp_valid && w_line_ok && !w_flush;

    rob_entry_table #(
        .DEPTH (DEPTH),
        .PTR_W (c_PTR_W)
    ) u_table (
        .clk            (clk),
        .rst            (rst),
        .i_flush_all    (w_flush),
        .i_alloc_en     (w_alloc),
        .i_alloc_idx    (r_tail),
        .i_alloc_tag    (alloc_tag),
        .i_alloc_is_st  (alloc_is_st),
        .i_cmp_en       (w_cmp_en),
        .i_cmp_idx      (cmp_line[c_PTR_W-1:0]),
        .i_cmp_tag      (cmp_tag),
        .i_cmp_data     (cmp_data),
        .i_cmp_is_flush (cmp_is_flush),
        .i_clr_en       (w_retire),
        .i_clr_idx      (r_head),
        .i_head_idx     (r_head),
        .o_head         (w_head)
    );

    // Head/tail pointers and occupancy; a flush collapses the ROB to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_alloc) - c_CNT_W'(w_retire);
        end
    end

    // Retire outputs: single-cycle pulses; tag/data hold their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_valid      <= 1'b0;
            ret_tag        <= '0;
            ret_data       <= '0;
            rob_valid      <= 1'b0;
            rob_ret_tag_in <= '0;
            rob_resteer    <= 1'b0;
        end else begin
            ret_valid   <= w_retire;
            rob_valid   <= w_retire && w_head.is_st;
            rob_resteer <= w_flush;
            if (w_retire) begin
                ret_tag  <= w_head.tag;
                ret_data <= w_head.data;
                if (w_head.is_st) begin
                    rob_ret_tag_in <= w_head.tag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_rob_retire_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_rob_retire_ctrl
//  Description : Self-checking bench for dc_rob_retire_ctrl with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dc_rob_retire_ctrl;

    localparam int DEPTH = 16;
    localparam int TW    = 10;
    localparam int LW    = 10;
    localparam int XW    = 32;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid = 1'b0;
    logic [TW-1:0] alloc_tag = '0;
    logic          alloc_is_st = 1'b0;
    logic          alloc_ready;
    logic [LW-1:0] alloc_line;
    logic          cmp_valid = 1'b0;
    logic [LW-1:0] cmp_line = '0;
    logic [TW-1:0] cmp_tag = '0;
    logic [XW-1:0] cmp_data = '0;
    logic          cmp_is_flush = 1'b0;
    logic [TW-1:0] rob_ret_tag_in;
    logic          rob_valid;
    logic          rob_resteer;
    logic          ret_valid;
    logic [TW-1:0] ret_tag;
    logic [XW-1:0] ret_data;
    logic [CW-1:0] count;

    dc_rob_retire_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_tag      (alloc_tag),
        .alloc_is_st    (alloc_is_st),
        .alloc_ready    (alloc_ready),
        .alloc_line     (alloc_line),
        .cmp_valid      (cmp_valid),
        .cmp_line       (cmp_line),
        .cmp_tag        (cmp_tag),
        .cmp_data       (cmp_data),
        .cmp_is_flush   (cmp_is_flush),
        .rob_ret_tag_in (rob_ret_tag_in),
        .rob_valid      (rob_valid),
        .rob_resteer    (rob_resteer),
        .ret_valid      (ret_valid),
        .ret_tag        (ret_tag),
        .ret_data       (ret_data),
        .count          (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding ops in program order.
    typedef struct {
        int            line;
        logic [TW-1:0] tag;
        bit            st;
        bit            done;
        bit            fl;
        logic [XW-1:0] data;
    } m_t;

    m_t            q[$];
    int            next_line = 0;
    logic          exp_ret_valid = 1'b0;
    logic [TW-1:0] exp_ret_tag = '0;
    logic [XW-1:0] exp_ret_data = '0;
    logic          exp_rob_valid = 1'b0;
    logic [TW-1:0] exp_rob_tag = '0;
    logic          exp_resteer = 1'b0;

    // Advance the model on every clock edge from the pre-edge contents.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            next_line     = 0;
            exp_ret_valid = 1'b0;
            exp_ret_tag   = '0;
            exp_ret_data  = '0;
            exp_rob_valid = 1'b0;
            exp_rob_tag   = '0;
            exp_resteer   = 1'b0;
        end else begin
            bit ready, retire, flush;
            m_t e;
            ready  = (q.size() < DEPTH);
            retire = (q.size() > 0) && q[0].done;
            flush  = retire && q[0].fl;
            exp_ret_valid = retire;
            exp_rob_valid = retire && q[0].st;
            exp_resteer   = flush;
            if (retire) begin
                exp_ret_tag  = q[0].tag;
                exp_ret_data = q[0].data;
                if (q[0].st) exp_rob_tag = q[0].tag;
            end
            if (flush) begin
                q.delete();
                next_line = 0;
            end else begin
                if (cmp_valid) begin
                    foreach (q[i]) begin
                        if (q[i].line == int'(cmp_line) && q[i].tag == cmp_tag) begin
                            q[i].done = 1'b1;
                            q[i].fl   = cmp_is_flush;
                            q[i].data = q[i].st ? '0 : cmp_data;
                        end
                    end
                end
                if (retire) void'(q.pop_front());
                if (alloc_valid && ready) begin
                    e.line = next_line;
                    e.tag  = alloc_tag;
                    e.st   = alloc_is_st;
                    e.done = 1'b0;
                    e.fl   = 1'b0;
                    e.data = '0;
                    q.push_back(e);
                    next_line = (next_line + 1) % DEPTH;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("ret_valid",      ret_valid,      exp_ret_valid);
        chk("ret_tag",        ret_tag,        exp_ret_tag);
        chk("ret_data",       ret_data,       exp_ret_data);
        chk("rob_valid",      rob_valid,      exp_rob_valid);
        chk("rob_ret_tag_in", rob_ret_tag_in, exp_rob_tag);
        chk("rob_resteer",    rob_resteer,    exp_resteer);
        chk("alloc_ready",    alloc_ready,    (q.size() < DEPTH) ? 1 : 0);
        chk("alloc_line",     alloc_line,     next_line);
        chk("count",          count,          q.size());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int tag, input bit st);
        alloc_valid = 1'b1;
        alloc_tag   = TW'(tag);
        alloc_is_st = st;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cmp(input int line, input int tag, input int data, input bit fl);
        cmp_valid    = 1'b1;
        cmp_line     = LW'(line);
        cmp_tag      = TW'(tag);
        cmp_data     = XW'(data);
        cmp_is_flush = fl;
        tick();
        cmp_valid    = 1'b0;
        cmp_is_flush = 1'b0;
    endtask

    task automatic reset_dut();
        #2 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Reset state
        chk("rst alloc_ready", alloc_ready, 1);
        chk("rst count", count, 0);
        chk("rst alloc_line", alloc_line, 0);
        chk("rst ret_valid", ret_valid, 0);
        chk("rst rob_valid", rob_valid, 0);
        chk("rst rob_resteer", rob_resteer, 0);

        // Mid-stream asynchronous reset with a completion pending
        for (int i = 0; i < 5; i++) do_alloc(40 + i, 1'b0);
        chk("five count", count, 5);
        cmp_valid = 1'b1; cmp_line = '0; cmp_tag = TW'(40); cmp_data = 32'h55;
        #2 rst = 1'b1;
        #1 chk("async count", count, 0);
        chk("async alloc_ready", alloc_ready, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        cmp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post-rst ret_valid", ret_valid, 0);
        end

        // Load path
        reset_dut();
        chk("load alloc_line", alloc_line, 0);
        do_alloc(17, 1'b0);
        chk("load count", count, 1);
        do_cmp(0, 17, 32'h30, 1'b0);
        chk("load latency", ret_valid, 0);
        tick();
        chk("load ret_valid", ret_valid, 1);
        chk("load ret_tag", ret_tag, 17);
        chk("load ret_data", ret_data, 32'h30);
        chk("load rob_valid", rob_valid, 0);
        chk("load count after", count, 0);
        tick();
        chk("load pulse", ret_valid, 0);

        // Store path
        reset_dut();
        do_alloc(20, 1'b1);
        do_cmp(0, 20, 32'hdead, 1'b0);
        tick();
        chk("st rob_valid", rob_valid, 1);
        chk("st rob_ret_tag_in", rob_ret_tag_in, 20);
        chk("st ret_valid", ret_valid, 1);
        chk("st ret_data", ret_data, 0);
        tick();
        chk("st rob_valid pulse", rob_valid, 0);
        chk("st tag hold", rob_ret_tag_in, 20);

        // In-order retire of out-of-order completions
        reset_dut();
        do_alloc(1, 1'b0);
        do_alloc(2, 1'b0);
        do_alloc(3, 1'b0);
        do_cmp(1, 9, 32'h99, 1'b0);
        do_cmp(2, 3, 32'h33, 1'b0);
        do_cmp(1, 2, 32'h22, 1'b0);
        chk("ord no early retire", ret_valid, 0);
        chk("ord count", count, 3);
        do_cmp(0, 1, 32'h11, 1'b0);
        tick();
        chk("ord r1 tag", ret_tag, 1);
        chk("ord r1 data", ret_data, 32'h11);
        tick();
        chk("ord r2 valid", ret_valid, 1);
        chk("ord r2 tag", ret_tag, 2);
        chk("ord r2 data", ret_data, 32'h22);
        tick();
        chk("ord r3 tag", ret_tag, 3);
        chk("ord r3 data", ret_data, 32'h33);
        tick();
        chk("ord done", ret_valid, 0);
        chk("ord count0", count, 0);

        // Full ROB and tail wrap
        reset_dut();
        for (int i = 0; i < DEPTH; i++) do_alloc(100 + i, 1'b0);
        chk("full ready", alloc_ready, 0);
        chk("full count", count, 16);
        do_cmp(0, 100, 32'h100, 1'b0);
        alloc_valid = 1'b1;
        alloc_tag   = TW'(200);
        alloc_is_st = 1'b0;
        tick();
        chk("full ret_tag", ret_tag, 100);
        chk("full refused count", count, 15);
        chk("full ready again", alloc_ready, 1);
        chk("full wrap line", alloc_line, 0);
        tick();
        alloc_valid = 1'b0;
        chk("wrap count", count, 16);
        chk("wrap line next", alloc_line, 1);
        chk("wrap ready", alloc_ready, 0);

        // Flush: retire, resteer, drop same-cycle writes and later stale completions
        reset_dut();
        do_alloc(4, 1'b0);
        do_alloc(5, 1'b0);
        do_alloc(6, 1'b0);
        do_cmp(0, 4, 32'h44, 1'b1);
        alloc_valid = 1'b1;
        alloc_tag   = TW'(7);
        cmp_valid   = 1'b1;
        cmp_line    = LW'(1);
        cmp_tag     = TW'(5);
        tick();
        alloc_valid = 1'b0;
        cmp_valid   = 1'b0;
        chk("fl ret_valid", ret_valid, 1);
        chk("fl ret_tag", ret_tag, 4);
        chk("fl resteer", rob_resteer, 1);
        chk("fl count", count, 0);
        chk("fl line", alloc_line, 0);
        do_cmp(1, 5, 32'h55, 1'b0);
        chk("fl resteer pulse", rob_resteer, 0);
        do_cmp(2, 6, 32'h66, 1'b0);
        tick();
        chk("fl stale ignored", ret_valid, 0);
        chk("fl count stays", count, 0);

        // Random traffic against the model
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            alloc_valid  = ($urandom_range(0, 99) < 55);
            alloc_tag    = TW'($urandom);
            alloc_is_st  = 1'($urandom_range(0, 1));
            cmp_valid    = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
                k        = $urandom_range(0, q.size() - 1);
                cmp_line = LW'(q[k].line);
                cmp_tag  = ($urandom_range(0, 9) == 0) ? TW'($urandom) : q[k].tag;
            end else begin
                cmp_line = LW'($urandom_range(0, 20));
                cmp_tag  = TW'($urandom);
            end
            cmp_data     = $urandom;
            cmp_is_flush = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) reset_dut();
            else tick();
        end
        alloc_valid  = 1'b0;
        cmp_valid    = 1'b0;
        cmp_is_flush = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
